// File: rtl/graph_mem_arbiter_pkg.sv
// graph_mem_pkg: shared types and constants for the graph memory arbiter.
//   req_kind_e  - request class (row-index read / edge-data read)
//   mem_tag_t   - in-flight read tag {valid, issuing processor ID}
//   MEM_LAT_DEFAULT - default memory read latency in cycles
package graph_mem_pkg;

  localparam int MEM_LAT_DEFAULT = 2;
  // Tag ID field is sized for the widest supported PROC_BITS.
  localparam int TAG_ID_W = 8;

  typedef enum logic {
    KIND_IDX  = 1'b0,
    KIND_DATA = 1'b1
  } req_kind_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } mem_tag_t;

endpackage

// File: rtl/graph_mem_arbiter_if.sv
// graph_mem_arbiter_if: bundles the processor-side request/response lanes and
// the graph_memory address/data lines.
//   slave  - the arbiter (takes requests and memory data, drives the rest)
//   master - the surroundings (processor array + memory)
interface graph_mem_arbiter_if #(
  parameter int NUM_PROC  = 4,
  parameter int PROC_BITS = 4
);
  logic [NUM_PROC-1:0]        req_valid_in;
  logic [NUM_PROC-1:0]        req_kind_in;
  logic [NUM_PROC-1:0][31:0]  req_addr_in;
  logic [NUM_PROC-1:0]        req_ready_out;
  logic [NUM_PROC-1:0]        resp_valid_out;
  logic [NUM_PROC-1:0]        resp_kind_out;
  logic [NUM_PROC-1:0][31:0]  resp_data_out;
  logic [31+PROC_BITS:0]      idx_addr_out;
  logic                       idx_valid_out;
  logic [31+PROC_BITS:0]      data_addra_out;
  logic [31+PROC_BITS:0]      data_addrb_out;
  logic                       data_valida_out;
  logic                       data_validb_out;
  logic [31:0]                rowidx_in;
  logic [31:0]                data_a_in;
  logic [31:0]                data_b_in;

  modport slave (
    input  req_valid_in, req_kind_in, req_addr_in, rowidx_in, data_a_in, data_b_in,
    output req_ready_out, resp_valid_out, resp_kind_out, resp_data_out,
           idx_addr_out, idx_valid_out, data_addra_out, data_addrb_out,
           data_valida_out, data_validb_out
  );

  modport master (
    output req_valid_in, req_kind_in, req_addr_in, rowidx_in, data_a_in, data_b_in,
    input  req_ready_out, resp_valid_out, resp_kind_out, resp_data_out,
           idx_addr_out, idx_valid_out, data_addra_out, data_addrb_out,
           data_valida_out, data_validb_out
  );
endinterface

// File: rtl/graph_mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin find-first-set.
//   mask    - request bits
//   ptr     - search start position (< N)
//   gnt_vld - some bit of mask is set
//   gnt_idx - first set position at or after ptr, wrapping
module rr_picker #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         gnt_vld,
  output logic [W-1:0] gnt_idx
);
  // Rotate so that bit 0 of rot corresponds to position ptr.
  logic [2*N-1:0] rot;
  assign rot = {mask, mask} >> ptr;

  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Walk downward so the smallest offset from ptr wins.
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) begin
        j = int'(ptr) + i;
        if (j >= N) j = j - N;
        gnt_vld = 1'b1;
        gnt_idx = W'(j);
      end
    end
  end
endmodule

// File: rtl/graph_mem_arbiter.sv
// graph_mem_arbiter: shares one graph_memory (1 row-index port, 2 data ports,
// fixed MEM_LAT read latency) among NUM_PROC processors.
//   clk_in, rst_in - clock, async active-low reset
//   bus (slave)    - request/response lanes and memory address/data lines
// Per cycle: one round-robin idx grant, two round-robin data grants (A, B).
// Issued reads are tracked by {valid, id} tags; the tag leaving the pipe
// steers the matching memory word into that processor's response register.
module graph_mem_arbiter
  import graph_mem_pkg::*;
#(
  parameter int NUM_PROC  = 4,
  parameter int PROC_BITS = 4,
  parameter int MEM_LAT   = MEM_LAT_DEFAULT
) (
  input  logic clk_in,
  input  logic rst_in,
  graph_mem_arbiter_if.slave bus
);
  localparam int AW = 32 + PROC_BITS;

  function automatic logic [PROC_BITS-1:0] nxt(input logic [PROC_BITS-1:0] i);
    return (i == PROC_BITS'(NUM_PROC-1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [AW-1:0] mk_addr(input logic [PROC_BITS-1:0] id,
                                            input logic [NUM_PROC-1:0][31:0] a);
    logic [31:0] w;
    w = '0;
    for (int p = 0; p < NUM_PROC; p++)
      if (PROC_BITS'(p) == id) w = a[p];
    return {id, w};
  endfunction

  logic [NUM_PROC-1:0]  idx_mask, dat_mask, b_mask, rdy;
  logic [PROC_BITS-1:0] idx_ptr_q, idx_ptr_d, dat_ptr_q, dat_ptr_d, b_ptr;
  logic                 idx_gv, a_gv, b_gv, idx_go, a_go, b_go;
  logic [PROC_BITS-1:0] idx_gi, a_gi, b_gi;
  logic [AW-1:0]        idx_addr_q, idx_addr_d, a_addr_q, a_addr_d, b_addr_q, b_addr_d;

  assign idx_mask = bus.req_valid_in & ~bus.req_kind_in;
  assign dat_mask = bus.req_valid_in &  bus.req_kind_in;
  // Port B searches after the A grantee with A removed, so it never wraps onto A.
  assign b_mask   = dat_mask & ~(NUM_PROC'(1) << a_gi);
  assign b_ptr    = nxt(a_gi);

  rr_picker #(.N(NUM_PROC), .W(PROC_BITS)) u_pick_idx (
    .mask(idx_mask), .ptr(idx_ptr_q), .gnt_vld(idx_gv), .gnt_idx(idx_gi));
  rr_picker #(.N(NUM_PROC), .W(PROC_BITS)) u_pick_a (
    .mask(dat_mask), .ptr(dat_ptr_q), .gnt_vld(a_gv), .gnt_idx(a_gi));
  rr_picker #(.N(NUM_PROC), .W(PROC_BITS)) u_pick_b (
    .mask(b_mask), .ptr(b_ptr), .gnt_vld(b_gv), .gnt_idx(b_gi));

  // No grant may leave while reset is held.
  assign idx_go = idx_gv & rst_in;
  assign a_go   = a_gv   & rst_in;
  assign b_go   = b_gv   & rst_in;

  always_comb begin
    rdy = '0;
    if (idx_go) rdy = rdy | (NUM_PROC'(1) << idx_gi);
    if (a_go)   rdy = rdy | (NUM_PROC'(1) << a_gi);
    if (b_go)   rdy = rdy | (NUM_PROC'(1) << b_gi);
  end

  always_comb begin
    idx_ptr_d  = idx_go ? nxt(idx_gi) : idx_ptr_q;
    dat_ptr_d  = b_go ? nxt(b_gi) : (a_go ? nxt(a_gi) : dat_ptr_q);
    idx_addr_d = idx_go ? mk_addr(idx_gi, bus.req_addr_in) : idx_addr_q;
    a_addr_d   = a_go   ? mk_addr(a_gi,   bus.req_addr_in) : a_addr_q;
    b_addr_d   = b_go   ? mk_addr(b_gi,   bus.req_addr_in) : b_addr_q;
  end

  // Addresses pass through combinationally on a grant, else show the last one.
  assign bus.req_ready_out   = rdy;
  assign bus.idx_addr_out    = idx_addr_d;
  assign bus.data_addra_out  = a_addr_d;
  assign bus.data_addrb_out  = b_addr_d;
  assign bus.idx_valid_out   = idx_go;
  assign bus.data_valida_out = a_go;
  assign bus.data_validb_out = b_go;

  // Tag pipes: index 0 = idx port, 1 = data A, 2 = data B.
  mem_tag_t            tag_q [3][MEM_LAT];
  mem_tag_t            tag_d [3][MEM_LAT];
  mem_tag_t            tag_new [3];
  logic [2:0][31:0]    mem_word;

  assign mem_word = {bus.data_b_in, bus.data_a_in, bus.rowidx_in};

  always_comb begin
    tag_new[0] = '{valid: idx_go, id: TAG_ID_W'(idx_gi)};
    tag_new[1] = '{valid: a_go,   id: TAG_ID_W'(a_gi)};
    tag_new[2] = '{valid: b_go,   id: TAG_ID_W'(b_gi)};
    for (int s = 0; s < 3; s++) begin
      tag_d[s][0] = tag_new[s];
      for (int i = 1; i < MEM_LAT; i++) tag_d[s][i] = tag_q[s][i-1];
    end
  end

  logic [NUM_PROC-1:0]       resp_vld_q, resp_vld_d, resp_kind_q, resp_kind_d;
  logic [NUM_PROC-1:0][31:0] resp_data_q, resp_data_d;

  // Fixed latency plus one grant per requester means at most one tag hit per lane.
  always_comb begin
    resp_vld_d  = '0;
    resp_kind_d = resp_kind_q;
    resp_data_d = resp_data_q;
    for (int p = 0; p < NUM_PROC; p++) begin
      for (int s = 0; s < 3; s++) begin
        if (tag_q[s][MEM_LAT-1].valid && tag_q[s][MEM_LAT-1].id == TAG_ID_W'(p)) begin
          resp_vld_d[p]  = 1'b1;
          resp_kind_d[p] = (s == 0) ? KIND_IDX : KIND_DATA;
          resp_data_d[p] = mem_word[s];
        end
      end
    end
  end

  assign bus.resp_valid_out = resp_vld_q;
  assign bus.resp_kind_out  = resp_kind_q;
  assign bus.resp_data_out  = resp_data_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx_ptr_q   <= '0;
      dat_ptr_q   <= '0;
      idx_addr_q  <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      resp_vld_q  <= '0;
      resp_kind_q <= '0;
      resp_data_q <= '0;
      for (int s = 0; s < 3; s++)
        for (int i = 0; i < MEM_LAT; i++) tag_q[s][i] <= '0;
    end else begin
      idx_ptr_q   <= idx_ptr_d;
      dat_ptr_q   <= dat_ptr_d;
      idx_addr_q  <= idx_addr_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      resp_vld_q  <= resp_vld_d;
      resp_kind_q <= resp_kind_d;
      resp_data_q <= resp_data_d;
      for (int s = 0; s < 3; s++)
        for (int i = 0; i < MEM_LAT; i++) tag_q[s][i] <= tag_d[s][i];
    end
  end
endmodule

// File: tb/tb_graph_mem_arbiter.sv
// tb_graph_mem_arbiter: directed vector table for grants/addresses plus a
// response scoreboard fed from the table's expected grants; hand sequences
// cover reset values and reset during in-flight reads.
module tb_graph_mem_arbiter;
  localparam int NP  = 4;
  localparam int PB  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  graph_mem_arbiter_if #(.NUM_PROC(NP), .PROC_BITS(PB)) bif ();

  graph_mem_arbiter #(.NUM_PROC(NP), .PROC_BITS(PB), .MEM_LAT(LAT)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bif)
  );

  // Memory model: contents are a fixed function of the full {id, addr}.
  function automatic logic [31:0] row_word(input logic [35:0] a);
    return 32'hA000_0000 | {8'h00, a[35:32], 4'h0, a[15:0]};
  endfunction
  function automatic logic [31:0] dat_word(input logic [35:0] a);
    return 32'hD000_0000 | {8'h00, a[35:32], 4'h0, a[15:0]};
  endfunction

  logic [35:0] mi_q [2];
  logic [35:0] ma_q [2];
  logic [35:0] mb_q [2];
  always @(posedge clk) begin
    mi_q[0] <= bif.idx_addr_out;   mi_q[1] <= mi_q[0];
    ma_q[0] <= bif.data_addra_out; ma_q[1] <= ma_q[0];
    mb_q[0] <= bif.data_addrb_out; mb_q[1] <= mb_q[0];
  end
  assign bif.rowidx_in = row_word(mi_q[1]);
  assign bif.data_a_in = dat_word(ma_q[1]);
  assign bif.data_b_in = dat_word(mb_q[1]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Response scoreboard, indexed by the cycle the response must be visible.
  typedef struct packed { logic v; logic k; logic [31:0] d; } rsp_t;
  rsp_t exp_q [0:511][0:NP-1];
  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [NP-1:0] ev;
      ev = '0;
      for (int p = 0; p < NP; p++) ev[p] = exp_q[cyc][p].v;
      check("resp_valid", 64'(bif.resp_valid_out), 64'(ev));
      for (int p = 0; p < NP; p++) begin
        if (exp_q[cyc][p].v) begin
          check($sformatf("resp_kind[%0d]", p), 64'(bif.resp_kind_out[p]), 64'(exp_q[cyc][p].k));
          check($sformatf("resp_data[%0d]", p), 64'(bif.resp_data_out[p]), 64'(exp_q[cyc][p].d));
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  vld, kind;
    logic [31:0] base;
    logic [3:0]  rdy;
    logic        iv;  logic [3:0] iid;
    logic        va;  logic [3:0] aid;
    logic        vb;  logic [3:0] bid;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] kind,
                              input logic [31:0] base, input logic [3:0] rdy,
                              input logic iv, input logic [3:0] iid,
                              input logic va, input logic [3:0] aid,
                              input logic vb, input logic [3:0] bid);
    vec_t v;
    v.vld = vld; v.kind = kind; v.base = base; v.rdy = rdy;
    v.iv = iv; v.iid = iid; v.va = va; v.aid = aid; v.vb = vb; v.bid = bid;
    return v;
  endfunction

  logic [35:0] last_i = '0, last_a = '0, last_b = '0;
  vec_t idle_v;

  task automatic sched(input int c, input logic [3:0] id, input logic k, input logic [31:0] d);
    exp_q[c][int'(id)] = '{v: 1'b1, k: k, d: d};
  endtask

  // Called just after a rising edge; checks at the falling edge of the same cycle.
  task automatic apply(input vec_t v, input string nm);
    bif.req_valid_in = v.vld;
    bif.req_kind_in  = v.kind;
    for (int p = 0; p < NP; p++) bif.req_addr_in[p] = v.base;
    @(negedge clk);
    check({nm, ".ready"},  64'(bif.req_ready_out),   64'(v.rdy));
    check({nm, ".ivalid"}, 64'(bif.idx_valid_out),   64'(v.iv));
    check({nm, ".avalid"}, 64'(bif.data_valida_out), 64'(v.va));
    check({nm, ".bvalid"}, 64'(bif.data_validb_out), 64'(v.vb));
    if (v.iv) begin last_i = {v.iid, v.base}; sched(cyc + LAT + 1, v.iid, 1'b0, row_word(last_i)); end
    if (v.va) begin last_a = {v.aid, v.base}; sched(cyc + LAT + 1, v.aid, 1'b1, dat_word(last_a)); end
    if (v.vb) begin last_b = {v.bid, v.base}; sched(cyc + LAT + 1, v.bid, 1'b1, dat_word(last_b)); end
    check({nm, ".iaddr"}, 64'(bif.idx_addr_out),   64'(last_i));
    check({nm, ".aaddr"}, 64'(bif.data_addra_out), 64'(last_a));
    check({nm, ".baddr"}, 64'(bif.data_addrb_out), 64'(last_b));
    @(posedge clk); #1;
  endtask

  vec_t tbl [21];

  initial begin
    for (int c = 0; c < 512; c++)
      for (int p = 0; p < NP; p++) exp_q[c][p] = '0;
    idle_v = mk(4'h0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0);

    // Ready/grants are hand-computed from idx_ptr = dat_ptr = 0 after reset.
    tbl[0]  = mk(4'b0100, 4'b0000, 32'd5,  4'b0100, 1, 2, 0, 0, 0, 0); // single idx read
    tbl[1]  = idle_v;                                                 // address hold
    tbl[2]  = mk(4'b1011, 4'b1011, 32'h20, 4'b0011, 0, 0, 1, 0, 1, 1); // P0->A, P1->B
    tbl[3]  = mk(4'b1011, 4'b1011, 32'h21, 4'b1001, 0, 0, 1, 3, 1, 0); // P3->A, P0->B
    tbl[4]  = idle_v;
    tbl[5]  = mk(4'b0110, 4'b0100, 32'h40, 4'b0110, 1, 1, 1, 2, 0, 0); // mixed, B unused
    tbl[6]  = idle_v;
    for (int i = 0; i < 8; i++) begin                                 // idx fairness from ptr 2
      tbl[7+i] = mk(4'hF, 4'h0, 32'h60 + 32'(i), 4'(1 << ((i + 2) % 4)),
                    1, 4'((i + 2) % 4), 0, 0, 0, 0);
    end
    tbl[15] = mk(4'hF, 4'hF, 32'h80, 4'b1001, 0, 0, 1, 3, 1, 0);       // data backpressure
    tbl[16] = mk(4'hF, 4'hF, 32'h81, 4'b0110, 0, 0, 1, 1, 1, 2);
    tbl[17] = mk(4'hF, 4'hF, 32'h82, 4'b1001, 0, 0, 1, 3, 1, 0);
    tbl[18] = mk(4'hF, 4'hF, 32'h83, 4'b0110, 0, 0, 1, 1, 1, 2);
    tbl[19] = mk(4'hF, 4'b0101, 32'hA0, 4'b1101, 1, 3, 1, 0, 1, 2);    // three grants at once
    tbl[20] = idle_v;

    // Reset state with requests present.
    bif.req_valid_in = 4'hF;
    bif.req_kind_in  = 4'b0101;
    for (int p = 0; p < NP; p++) bif.req_addr_in[p] = 32'h77;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst.ready", 64'(bif.req_ready_out), 64'h0);
    check("rst.ivalid", 64'({bif.idx_valid_out, bif.data_valida_out, bif.data_validb_out}), 64'h0);
    check("rst.iaddr", 64'(bif.idx_addr_out), 64'h0);
    check("rst.data", 64'(bif.resp_data_out), 64'h0);
    check("rst.kind", 64'(bif.resp_kind_out), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 4; i++) apply(idle_v, "drain");

    // Pointers now: idx_ptr = 0, dat_ptr = 3. Three grants: idx P1, A P0, B P2.
    apply(mk(4'hF, 4'b0101, 32'hC0, 4'b0111, 1, 1, 1, 0, 1, 2), "pre_rst");
    rst_n = 1'b0;
    for (int c = cyc; c < cyc + 8; c++)
      for (int p = 0; p < NP; p++) exp_q[c][p] = '0;
    last_i = '0; last_a = '0; last_b = '0;
    bif.req_valid_in = 4'hF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("midrst.ready", 64'(bif.req_ready_out), 64'h0);
      check("midrst.valids", 64'({bif.idx_valid_out, bif.data_valida_out, bif.data_validb_out}), 64'h0);
      check("midrst.data", 64'(bif.resp_data_out), 64'h0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) apply(idle_v, "post_rst_idle");
    apply(mk(4'hF, 4'h0, 32'hE0, 4'b0001, 1, 0, 0, 0, 0, 0), "post_rst_idx");
    apply(mk(4'hF, 4'hF, 32'hE1, 4'b0011, 0, 0, 1, 0, 1, 1), "post_rst_dat");
    for (int i = 0; i < 5; i++) apply(idle_v, "final_drain");

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
